// File: rtl/ssd_scan_driver.sv
`timescale 1ns/1ps
// ssd_scan_driver: N-digit multiplexed seven-segment scan driver.
// Frame-synchronous double buffering, leading-zero blanking, per-digit DP,
// anti-ghosting guard at the start of each dwell and a frame_done strobe.
// Optional feature macro: SSD_BLINK_EN (adds blink_mask port and blink counter).
module ssd_scan_driver #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV_BITS  = 18,
    parameter int unsigned GUARD_CYCLES   = 16,
    parameter int unsigned ANODE_ACT_LOW  = 1,
    parameter int unsigned BLINK_DIV_BITS = 25
) (
    input  logic                    board_clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
`ifdef SSD_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic [6:0]              cathodes,
    output logic                    dp_out,
    output logic                    frame_done
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DIG_W = 4 * NUM_DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    // XOR mask turning an active-high one-hot select into pin polarity
    localparam logic [NUM_DIGITS-1:0] AN_OFF =
        (ANODE_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [SCAN_DIV_BITS-1:0] r_presc;
    logic [IDX_W-1:0]         r_idx;
    logic [DIG_W-1:0]         r_snap;
    logic [NUM_DIGITS-1:0]    r_dp_snap;
    logic                     r_load_pend;

    logic                     w_presc_wrap;
    logic                     w_frame_wrap;
    logic [3:0]               w_code;
    logic                     w_dp_sel;
    logic [NUM_DIGITS-1:0]    w_lz_blank;
    logic                     w_higher_zero;
    logic [NUM_DIGITS-1:0]    w_an_on;
    logic [6:0]               w_seg;

    assign w_presc_wrap = (r_presc == {SCAN_DIV_BITS{1'b1}});
    assign w_frame_wrap = w_presc_wrap && (r_idx == LAST_IDX);

`ifdef SSD_BLINK_EN
    logic [BLINK_DIV_BITS-1:0] r_blink;

    // Free-running blink phase counter, cleared only by reset
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_blink <= '0;
        end else begin
            r_blink <= r_blink + BLINK_DIV_BITS'(1);
        end
    end
`endif

    // Dwell prescaler and digit index; disable parks the scan at digit 0
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_presc    <= '0;
            r_idx      <= '0;
            frame_done <= 1'b0;
        end else if (!enable) begin
            r_presc    <= '0;
            r_idx      <= '0;
            frame_done <= 1'b0;
        end else begin
            r_presc    <= r_presc + SCAN_DIV_BITS'(1);
            frame_done <= w_frame_wrap;
            if (w_presc_wrap) begin
                r_idx <= w_frame_wrap ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    // Snapshot swaps only at a frame boundary so a frame never mixes old and new digits
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_snap      <= {DIG_W{1'b1}};
            r_dp_snap   <= '0;
            r_load_pend <= 1'b0;
        end else if (enable && w_frame_wrap && (r_load_pend || load)) begin
            r_snap      <= digits_in;
            r_dp_snap   <= dp_in;
            r_load_pend <= 1'b0;
        end else if (load) begin
            r_load_pend <= 1'b1;
        end
    end

    // Leading-zero mask, current digit select and anode gating
    always_comb begin
        w_code        = 4'hF;
        w_dp_sel      = 1'b0;
        w_lz_blank    = '0;
        w_higher_zero = 1'b1;
        w_an_on       = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            w_lz_blank[i] = blank_lz && (i != 0) && w_higher_zero &&
                            (r_snap[4*i +: 4] == 4'h0);
            w_higher_zero = w_higher_zero &&
                            ((r_snap[4*i +: 4] == 4'h0) || (r_snap[4*i +: 4] == 4'hF));
        end
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_code     = w_lz_blank[i] ? 4'hF : r_snap[4*i +: 4];
                w_dp_sel   = r_dp_snap[i];
                w_an_on[i] = 1'b1;
            end
        end
`ifdef SSD_BLINK_EN
        if (r_blink[BLINK_DIV_BITS-1] && ((blink_mask & w_an_on) != '0)) begin
            w_an_on = '0;
        end
`endif
        if (!enable || (r_presc < SCAN_DIV_BITS'(GUARD_CYCLES))) begin
            w_an_on = '0;
        end
    end

    // Code to active-low {Ca..Cg}
    always_comb begin
        w_seg = 7'b1111111;
        case (w_code)
            4'h0: w_seg = 7'b0000001;
            4'h1: w_seg = 7'b1001111;
            4'h2: w_seg = 7'b0010010;
            4'h3: w_seg = 7'b0000110;
            4'h4: w_seg = 7'b1001100;
            4'h5: w_seg = 7'b0100100;
            4'h6: w_seg = 7'b0100000;
            4'h7: w_seg = 7'b0001111;
            4'h8: w_seg = 7'b0000000;
            4'h9: w_seg = 7'b0000100;
            4'hA: w_seg = 7'b0001000;
            4'hB: w_seg = 7'b1100000;
            4'hC: w_seg = 7'b0110001;
            4'hD: w_seg = 7'b1000010;
            4'hE: w_seg = 7'b0110000;
            default: w_seg = 7'b1111111;
        endcase
    end

    // Registered pin drivers, one clock behind the scan counters
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            anodes   <= AN_OFF;
            cathodes <= 7'h7F;
            dp_out   <= 1'b1;
        end else begin
            anodes   <= w_an_on ^ AN_OFF;
            cathodes <= w_seg;
            dp_out   <= ~w_dp_sel;
        end
    end

endmodule
